// File: rtl/alu_drv_pkg.sv
// Shared types for the ALU command driver slice: opcodes, the queued
// command bundle, driver FSM states and result width.
package alu_drv_pkg;

    localparam int RESULT_W  = 9;
    localparam int OP_W      = 3;
    localparam int DATA_W    = 8;
    localparam int CMD_TAG_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_NOP = 3'b000,
        OP_ADD = 3'b001,
        OP_AND = 3'b010,
        OP_XOR = 3'b011
    } alu_op_t;

    // op is kept as raw bits so 1xx codes reach the ALU untouched
    typedef struct packed {
        logic [OP_W-1:0]      op;
        logic [DATA_W-1:0]    a;
        logic [DATA_W-1:0]    b;
        logic [CMD_TAG_W-1:0] tag;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } drv_state_t;

    function automatic logic is_nop(input logic [OP_W-1:0] op);
        return op == OP_NOP;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO of alu_cmd_t entries with full/empty flags.
// Ports: clk, reset, push/wr_data, pop/rd_data (show-ahead), full, empty.
module alu_cmd_fifo
    import alu_drv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  alu_cmd_t wr_data,
    input  logic     pop,
    output alu_cmd_t rd_data,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    // one extra pointer bit tells full from empty when indices match
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    alu_cmd_t    mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/alu_cmd_driver.sv
// Command stage in front of the single-cycle ALU: queues commands, issues
// each with a one-cycle alu_start, waits for alu_done, returns a tagged
// result on a valid/ready response port.
// Ports: cmd_* (request in), rsp_* (response out), alu_* (ALU side).
// Build option: ALU_DRV_TIMEOUT_EN adds a WAIT timeout that reports rsp_err.
module alu_cmd_driver
    import alu_drv_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TAG_W       = CMD_TAG_W,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_op,
    input  logic [7:0]          cmd_a,
    input  logic [7:0]          cmd_b,
    input  logic [TAG_W-1:0]    cmd_tag,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [RESULT_W-1:0] rsp_result,
    output logic [TAG_W-1:0]    rsp_tag,
    output logic                rsp_err,
    output logic                alu_start,
    output logic [2:0]          alu_op,
    output logic [7:0]          alu_a,
    output logic [7:0]          alu_b,
    input  logic                alu_done,
    input  logic [RESULT_W-1:0] alu_result
);

    alu_cmd_t   cmd_in;
    alu_cmd_t   fifo_out;
    alu_cmd_t   cmd_q;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    logic       cap_res;
    logic       clr_res;
    logic       tmo_hit;
    drv_state_t state;
    drv_state_t state_n;

    assign cmd_in = '{op: cmd_op, a: cmd_a, b: cmd_b, tag: cmd_tag};
    assign cmd_ready = !fifo_full;

    alu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (cmd_valid),
        .wr_data (cmd_in),
        .pop     (pop),
        .rd_data (fifo_out),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // ALU operands come straight from cmd_q, which only reloads on the
    // edge entering ISSUE, so they hold until the next issue.
    assign alu_op  = cmd_q.op;
    assign alu_a   = cmd_q.a;
    assign alu_b   = cmd_q.b;
    assign rsp_tag = cmd_q.tag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        pop       = 1'b0;
        alu_start = 1'b0;
        rsp_valid = 1'b0;
        cap_res   = 1'b0;
        clr_res   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                // NOP never reaches the ALU and answers with zero
                alu_start = !is_nop(cmd_q.op);
                if (is_nop(cmd_q.op)) begin
                    clr_res = 1'b1;
                    state_n = RESP;
                end else begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                // alu_done takes priority over an expiring timeout
                if (alu_done) begin
                    cap_res = 1'b1;
                    state_n = RESP;
                end else if (tmo_hit) begin
                    clr_res = 1'b1;
                    state_n = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_n = ISSUE;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_q      <= '0;
            rsp_result <= '0;
        end else begin
            if (pop)     cmd_q      <= fifo_out;
            if (cap_res) rsp_result <= alu_result;
            if (clr_res) rsp_result <= '0;
        end
    end

`ifdef ALU_DRV_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] tmo_cnt;

    // counts WAIT cycles; held at zero outside WAIT so entry starts clean
    always_ff @(posedge clk or posedge reset) begin
        if (reset)              tmo_cnt <= '0;
        else if (state != WAIT) tmo_cnt <= '0;
        else                    tmo_cnt <= tmo_cnt + TMO_W'(1);
    end

    assign tmo_hit = (state == WAIT) && (tmo_cnt == TMO_LAST);

    // err is decided on the edge into RESP: only a WAIT exit without done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_err <= 1'b0;
        end else if (state != RESP && state_n == RESP) begin
            rsp_err <= (state == WAIT) && !alu_done;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed + randomized bench for alu_cmd_driver with an ALU stand-in
// and an in-order expected-response queue.
module tb_alu_cmd_driver;

    localparam int DEPTH = 4;
    localparam int TW    = 4;
    localparam int TMO   = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = '0;
    logic [7:0]    cmd_a = '0;
    logic [7:0]    cmd_b = '0;
    logic [TW-1:0] cmd_tag = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [8:0]    rsp_result;
    logic [TW-1:0] rsp_tag;
    logic          rsp_err;
    logic          alu_start;
    logic [2:0]    alu_op;
    logic [7:0]    alu_a;
    logic [7:0]    alu_b;
    logic          alu_done = 1'b0;
    logic [8:0]    alu_result = '0;

    alu_cmd_driver #(
        .FIFO_DEPTH  (DEPTH),
        .TAG_W       (TW),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_tag    (cmd_tag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_tag    (rsp_tag),
        .rsp_err    (rsp_err),
        .alu_start  (alu_start),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_done   (alu_done),
        .alu_result (alu_result)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int starts = 0;
    bit alu_en = 1'b1;
    logic pend = 1'b0;
    logic [8:0] pend_res = '0;

    typedef struct {
        logic [8:0]    res;
        logic [TW-1:0] tag;
        logic          err;
    } exp_t;

    exp_t expq[$];

    always @(posedge clk) cyc++;

    function automatic logic [8:0] ref_alu(input logic [2:0] op,
                                           input logic [7:0] a,
                                           input logic [7:0] b);
        int r;
        case (op)
            3'd1:    r = int'(a) + int'(b);
            3'd2:    r = int'(a & b);
            3'd3:    r = int'(a ^ b);
            default: r = 0;
        endcase
        return r[8:0];
    endfunction

    // ALU stand-in: answers one cycle after a start pulse
    always @(negedge clk) begin
        alu_done   = pend;
        alu_result = pend_res;
        if (alu_start) starts++;
        pend     = alu_start && alu_en;
        pend_res = ref_alu(alu_op, alu_a, alu_b);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [TW-1:0] tag,
                        input int budget, output bit ok, output int acc);
        exp_t e;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_tag   = tag;
        ok        = 1'b0;
        acc       = -1;
        for (int i = 0; i < budget; i++) begin
            if (cmd_ready) begin
                tick();
                ok  = 1'b1;
                acc = cyc;
                break;
            end
            tick();
        end
        cmd_valid = 1'b0;
        if (ok) begin
            e.tag = tag;
            if (op != 3'd0 && !alu_en) begin
                e.res = '0;
                e.err = 1'b1;
            end else begin
                e.res = ref_alu(op, a, b);
                e.err = 1'b0;
            end
            expq.push_back(e);
        end
    endtask

    task automatic recv(input string name, input int budget,
                        output int seen);
        bit   found;
        exp_t e;
        found     = 1'b0;
        seen      = -1;
        rsp_ready = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (rsp_valid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk({name, "_valid"}, 64'(found), 64'd1);
        if (found && expq.size() > 0) begin
            e    = expq.pop_front();
            seen = cyc;
            chk({name, "_res"}, 64'(rsp_result), 64'(e.res));
            chk({name, "_tag"}, 64'(rsp_tag), 64'(e.tag));
            chk({name, "_err"}, 64'(rsp_err), 64'(e.err));
            tick();
        end
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int e0, e1, c0, c1, s0, acc, n, stale;

        #2 reset = 1'b1;
        tick();
        tick();
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_result, rsp_tag}, 64'd0);
        chk("rst_alu", {alu_start, alu_op, alu_a, alu_b}, 64'd0);
        reset = 1'b0;
        tick();

        // ADD with carry out, latency and single start pulse
        s0 = starts;
        send(3'd1, 8'hFF, 8'h01, 4'd2, 4, ok, e0);
        chk("add_acc", 64'(ok), 64'd1);
        tick();
        chk("add_lat1", 64'(rsp_valid), 64'd0);
        tick();
        chk("add_lat2", 64'(rsp_valid), 64'd0);
        tick();
        chk("add_lat3", 64'(rsp_valid), 64'd1);
        recv("add", 20, c0);
        chk("add_cycle", 64'(c0 - e0), 64'd3);
        chk("add_starts", 64'(starts - s0), 64'd1);

        // AND then XOR back to back
        send(3'd2, 8'hF0, 8'h3C, 4'd3, 4, ok, e0);
        send(3'd3, 8'hAA, 8'hFF, 4'd4, 4, ok, e1);
        recv("and", 20, c0);
        recv("xor", 20, c1);
        chk("b2b_gap", 64'(c1 - c0), 64'd3);

        // NOP never starts the ALU
        s0 = starts;
        send(3'd0, 8'h5A, 8'hA5, 4'd7, 4, ok, e0);
        recv("nop", 20, c0);
        chk("nop_cycle", 64'(c0 - e0), 64'd2);
        chk("nop_starts", 64'(starts - s0), 64'd0);

        // capacity: depth + cmd_q, sixth push refused
        n = 0;
        for (int i = 0; i < 6; i++) begin
            send(3'(1 + i % 3), 8'(i * 16 + 3), 8'(i * 7 + 1),
                 TW'(i + 8), 3, ok, acc);
            n += int'(ok);
        end
        chk("cap_accepted", 64'(n), 64'd5);
        chk("cap_ready_low", 64'(cmd_ready), 64'd0);
        for (int i = 0; i < 5; i++) recv("cap", 20, c0);
        chk("cap_ready_back", 64'(cmd_ready), 64'd1);

        // reset in the middle of a stream drops everything
        send(3'd1, 8'h11, 8'h22, 4'd5, 4, ok, e0);
        send(3'd3, 8'h33, 8'h44, 4'd6, 4, ok, e1);
        tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", 64'(cmd_ready), 64'd1);
        chk("mid_rst_rsp", {rsp_valid, rsp_err, rsp_result, rsp_tag},
            64'd0);
        chk("mid_rst_alu", {alu_start, alu_op, alu_a, alu_b}, 64'd0);
        expq.delete();
        tick();
        reset     = 1'b0;
        rsp_ready = 1'b1;
        stale     = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (rsp_valid || alu_start) stale++;
        end
        rsp_ready = 1'b0;
        chk("mid_rst_stale", 64'(stale), 64'd0);

        // randomized bursts against the in-order model
        for (int r = 0; r < 15; r++) begin
            n = int'($urandom_range(1, 5));
            for (int i = 0; i < n; i++) begin
                send(3'($urandom_range(0, 7)), 8'($urandom),
                     8'($urandom), TW'($urandom), 4, ok, acc);
                chk("rnd_acc", 64'(ok), 64'd1);
            end
            for (int i = 0; i < n; i++) recv("rnd", 20, c0);
        end

`ifdef ALU_DRV_TIMEOUT_EN
        alu_en = 1'b0;
        send(3'd1, 8'h10, 8'h20, 4'd9, 4, ok, e0);
        recv("tmo", 40, c0);
        chk("tmo_cycle", 64'(c0 - e0), 64'(TMO + 2));
        alu_en = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
